// File: rtl/fetch_stage.sv
// Instruction fetch stage with one-entry skid buffer and redirect/discard handling.
// Optional perf counters (stall_cycles, flush_count) enabled by FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {FETCH, BUFFERED, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] tgt_hold;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc4;
  logic        redirect;
  logic [31:0] redirect_tgt;

  assign redirect     = branch_taken | jump;
  assign redirect_tgt = branch_taken ? branch_target : jump_target;
  assign pc_plus4     = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (redirect)                  state_nxt = imem_ack ? FETCH : DISCARD;
        else if (imem_ack && stall)    state_nxt = BUFFERED;
      end
      BUFFERED: begin
        if (redirect || !stall)        state_nxt = FETCH;
      end
      DISCARD: begin
        if (imem_ack)                  state_nxt = FETCH;
      end
      default:                         state_nxt = FETCH;
    endcase
  end

  // In DISCARD pc still holds the abandoned address, so the request stays stable.
  always_comb begin
    imem_req  = (state != BUFFERED);
    imem_addr = pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_id_inst  <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else begin
      if (redirect) if_id_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (redirect) begin
            if (imem_ack) pc       <= redirect_tgt;
            else          tgt_hold <= redirect_tgt;
          end else if (imem_ack) begin
            pc <= pc_plus4;
            if (stall) begin
              buf_inst <= imem_rdata;
              buf_pc4  <= pc_plus4;
            end else begin
              if_id_inst  <= imem_rdata;
              if_id_pc4   <= pc_plus4;
              if_id_valid <= 1'b1;
            end
          end else if (!stall) begin
            if_id_valid <= 1'b0;
          end
        end
        BUFFERED: begin
          if (redirect) begin
            pc <= redirect_tgt;
          end else if (!stall) begin
            if_id_inst  <= buf_inst;
            if_id_pc4   <= buf_pc4;
            if_id_valid <= 1'b1;
          end
        end
        DISCARD: begin
          // A redirect landing together with the ack goes straight to the new target.
          if (redirect) begin
            if (imem_ack) pc       <= redirect_tgt;
            else          tgt_hold <= redirect_tgt;
          end else begin
            if (imem_ack) pc <= tgt_hold;
            if (!stall)   if_id_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (redirect)   flush_count  <= flush_count + 32'd1;
      else if (stall) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a transaction-level model predicts the fetch
// request and IF/ID contents; monitors pop predictions and compare against the DUT.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, imem_ack;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_inst, if_id_pc4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  typedef struct packed {
    bit          chk;
    bit          req;
    logic [31:0] addr;
  } req_exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    bit          valid;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } out_exp_t;

  req_exp_t req_q[$];
  out_exp_t out_q[$];

  int checks = 0;
  int passes = 0;

  // Reference model: program counter, an optional held instruction, and an
  // optional outstanding response that must be thrown away.
  logic [31:0] m_pc, m_tgt, m_held_inst, m_held_pc4, m_inst, m_pc4;
  bit          m_valid, m_holding, m_dropping, m_known;
  logic [31:0] m_scnt, m_fcnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_step(input bit rst, input bit st, input bit br,
                                     input logic [31:0] bt, input bit jp,
                                     input logic [31:0] jt, input bit ack,
                                     input logic [31:0] data);
    logic [31:0] t;
    bit          rd;
    if (rst) begin
      m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 0;
      m_holding = 0; m_dropping = 0; m_scnt = 0; m_fcnt = 0; m_known = 1;
      return;
    end
    rd = br | jp;
    t  = br ? bt : jt;
    if (rd) begin
      m_fcnt++;
      m_valid = 0;
      if (m_holding) begin
        m_holding = 0; m_pc = t;
      end else if (ack) begin
        m_dropping = 0; m_pc = t;
      end else begin
        m_dropping = 1; m_tgt = t;
      end
      return;
    end
    if (st) m_scnt++;
    if (m_dropping) begin
      if (ack) begin m_pc = m_tgt; m_dropping = 0; end
      if (!st) m_valid = 0;
    end else if (m_holding) begin
      if (!st) begin
        m_inst = m_held_inst; m_pc4 = m_held_pc4; m_valid = 1; m_holding = 0;
      end
    end else if (ack) begin
      if (st) begin
        m_held_inst = data; m_held_pc4 = m_pc + 4; m_holding = 1;
      end else begin
        m_inst = data; m_pc4 = m_pc + 4; m_valid = 1;
      end
      m_pc = m_pc + 4;
    end else if (!st) begin
      m_valid = 0;
    end
  endfunction

  task automatic cyc(input bit rst, input bit st, input bit br, input logic [31:0] bt,
                     input bit jp, input logic [31:0] jt, input bit ack);
    logic [31:0] data;
    @(negedge clk);
    req_q.push_back('{m_known, !m_holding, m_pc});
    data = ack ? mem_word(m_pc) : $urandom;
    reset = rst; stall = st; branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt; imem_ack = ack; imem_rdata = data;
    model_step(rst, st, br, bt, jp, jt, ack, data);
    out_q.push_back('{m_inst, m_pc4, m_valid, m_scnt, m_fcnt});
  endtask

  // Request side is a function of state only: sample mid-cycle.
  initial begin
    req_exp_t e;
    forever begin
      @(negedge clk); #2;
      if (req_q.size() > 0) begin
        e = req_q.pop_front();
        if (e.chk) begin
          check("imem_req", {31'd0, imem_req}, {31'd0, e.req});
          check("imem_addr", imem_addr, e.addr);
        end
      end
    end
  end

  initial begin
    out_exp_t e;
    forever begin
      @(posedge clk); #1;
      if (out_q.size() > 0) begin
        e = out_q.pop_front();
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
        check("if_id_pc4", if_id_pc4, e.pc4);
        check("if_id_inst", if_id_inst, e.inst);
`ifdef FETCH_PERF_CNT_EN
        check("stall_cycles", stall_cycles, e.scnt);
        check("flush_count", flush_count, e.fcnt);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bt, jt;
    m_known = 0; m_holding = 0; m_dropping = 0; m_pc = 0;
    reset = 1; stall = 0; branch_taken = 0; jump = 0; imem_ack = 0;
    branch_target = 0; jump_target = 0; imem_rdata = 0;
    // Straight-line fetch after reset
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h40, 1, 32'h80, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
    // Ack at 0x10 under a three-cycle stall
    cyc(0, 0, 0, 0, 1, 32'h10, 1);
    cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Branch while the request is outstanding
    cyc(0, 0, 1, 32'h100, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    // Branch beats jump, and both beat stall
    cyc(0, 1, 1, 32'h200, 1, 32'h300, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    // Address wrap
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    // Five stalls then two redirects, then reset mid-run
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h20, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 32'h30, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bt = $urandom & 32'hFFFF_FFFC;
      jt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) bt = 32'hFFFF_FFF8;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 9) == 0, bt, $urandom_range(0, 9) == 0, jt,
          $urandom_range(0, 1) == 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", req_q.size() + out_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
